// File: rtl/dmem_pkg.sv
// Shared types for the c2c_data memory responder: FSM states and the latched request.
package dmem_pkg;
  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wmask;
    logic              re;
    logic              we;
    logic              err;
  } dmem_req_t;

  // lim is one past the last legal byte, kept at XLEN+1 bits so a window at the top of memory does not wrap.
  function automatic logic req_err(input logic [XLEN-1:0] addr, input logic re, input logic we,
                                   input logic [XLEN-1:0] base, input logic [XLEN:0] lim);
    return (re & we) | (addr[1:0] != 2'b00) |
           ({1'b0, addr} < {1'b0, base}) | ({1'b0, addr} >= lim);
  endfunction
endpackage

// File: rtl/dmem_if.sv
// c2c_data bus between the load/store unit (master) and the memory responder (slave).
interface dmem_if;
  import dmem_pkg::*;

  logic [XLEN-1:0]   addr;
  logic              re;
  logic              we;
  logic [XLEN-1:0]   wdata;
  logic [STRB_W-1:0] wmask;
  logic [XLEN-1:0]   rdata;
  logic              ack;
  logic              err;

  modport master (output addr, re, we, wdata, wmask, input rdata, ack, err);
  modport slave  (input addr, re, we, wdata, wmask, output rdata, ack, err);
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with byte write enables and a registered, read-first output; no reset.
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [STRB_W-1:0] wmask,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata_q <= mem[idx];
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Slave end of the c2c_data bus: captures one request, waits LATENCY cycles,
// commits to the word array and returns a one-cycle ack with data or err.
module dmem_responder import dmem_pkg::*; #(
  parameter int              DEPTH_WORDS = 1024,
  parameter int              LATENCY     = 2,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int             IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0]  LIM_ADDR = {1'b0, BASE_ADDR} + (XLEN+1)'(4 * DEPTH_WORDS);
  localparam logic [3:0]     LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        rd_sel_q, rd_sel_d;

  dmem_req_t        bus_req, cur_req;
  logic             mem_en;
  logic [IDX_W-1:0] mem_idx;
  logic [XLEN-1:0]  mem_rdata;

  always_comb begin
    bus_req.addr  = bus.addr;
    bus_req.wdata = bus.wdata;
    bus_req.wmask = bus.wmask;
    bus_req.re    = bus.re;
    bus_req.we    = bus.we;
    bus_req.err   = req_err(bus.addr, bus.re, bus.we, BASE_ADDR, LIM_ADDR);
  end

  // With zero wait states the commit happens on the capture edge, so the array sees the live bus.
  assign cur_req = (state_q == IDLE) ? bus_req : req_q;
  assign mem_idx = IDX_W'((cur_req.addr - BASE_ADDR) >> 2);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rd_sel_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.re | bus.we) begin
          req_d = bus_req;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESP) begin
      ack_d    = 1'b1;
      err_d    = cur_req.err;
      rd_sel_d = cur_req.re & ~cur_req.err;
    end
  end

  // Reset must never let a pending request reach the array.
  assign mem_en = (state_d == RESP) & ~cur_req.err & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      req_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (cur_req.we),
    .idx   (mem_idx),
    .wmask (cur_req.wmask),
    .wdata (cur_req.wdata),
    .rdata (mem_rdata)
  );

  assign bus.rdata = rd_sel_q ? mem_rdata : '0;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: three instances (latency 0/2/3, different base
// addresses including the top of the address space) checked against a word-array model.
module tb_dmem_responder;
  localparam int          DEPTH     = 64;
  localparam int          LAT   [3] = '{0, 2, 3};
  localparam logic [31:0] BASES [3] = '{32'h0000_0000, 32'h0000_1000, 32'hFFFF_FF00};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [31:0] addr_a  [3];
  logic [31:0] wdata_a [3];
  logic [3:0]  wmask_a [3];
  logic        re_a    [3];
  logic        we_a    [3];
  wire  [31:0] rdata_a [3];
  wire         ack_a   [3];
  wire         err_a   [3];

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] mdl [3][DEPTH];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_if bus ();
    assign bus.addr   = addr_a[g];
    assign bus.re     = re_a[g];
    assign bus.we     = we_a[g];
    assign bus.wdata  = wdata_a[g];
    assign bus.wmask  = wmask_a[g];
    assign rdata_a[g] = bus.rdata;
    assign ack_a[g]   = bus.ack;
    assign err_a[g]   = bus.err;
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT[g]), .BASE_ADDR(BASES[g])) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(int d, logic [31:0] a, logic r, logic w);
    longint unsigned la = a;
    longint unsigned lo = BASES[d];
    longint unsigned hi = lo + 4 * DEPTH;
    return (r && w) || (la % 4 != 0) || (la < lo) || (la >= hi);
  endfunction

  function automatic int word_idx(int d, logic [31:0] a);
    longint unsigned la = a;
    longint unsigned lo = BASES[d];
    return int'((la - lo) / 4);
  endfunction

  function automatic logic [31:0] rand_addr(int d);
    int s = $urandom_range(0, 9);
    logic [31:0] b = BASES[d];
    case (s)
      0:       return b + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      1:       return b - 32'(4 * $urandom_range(1, 8));
      2:       return b + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
      default: return b + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  task automatic wait_ack(input int d, output int cyc, output logic ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      ok = ack_a[d];
    end
    chk("ack_seen", ok, 1);
  endtask

  task automatic op(input int d, input logic [31:0] a, input logic r, input logic w,
                    input logic [31:0] wd, input logic [3:0] wm, output logic [31:0] rd);
    logic e, ok, gerr;
    logic [31:0] exp_rd;
    int cyc, idx;
    e      = exp_err(d, a, r, w);
    idx    = e ? 0 : word_idx(d, a);
    exp_rd = (r && !e) ? mdl[d][idx] : 32'h0;
    @(negedge clk);
    addr_a[d] = a; re_a[d] = r; we_a[d] = w; wdata_a[d] = wd; wmask_a[d] = wm;
    wait_ack(d, cyc, ok);
    rd   = rdata_a[d];
    gerr = err_a[d];
    re_a[d] = 1'b0; we_a[d] = 1'b0;
    chk("latency", cyc, LAT[d] + 1);
    chk("err", gerr, e);
    chk("rdata", rd, exp_rd);
    @(posedge clk); #1;
    chk("ack_pulse", ack_a[d], 0);
    if (w && !e)
      for (int b = 0; b < 4; b++)
        if (wm[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    logic [31:0] rd, a, exp_rd;
    int cyc, nacks;
    logic ok;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      addr_a[d] = '0; re_a[d] = 1'b0; we_a[d] = 1'b0; wdata_a[d] = '0; wmask_a[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ack", ack_a[d], 0);
      chk("rst_err", err_a[d], 0);
      chk("rst_rdata", rdata_a[d], 0);
    end
    @(negedge clk); reset = 1'b0;

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < DEPTH; i++)
        op(d, BASES[d] + 32'(4 * i), 1'b0, 1'b1, $urandom, 4'hF, rd);

    // write/read at latency 2
    op(1, BASES[1] + 32'h40, 1'b0, 1'b1, 32'hA5A5_1234, 4'hF, rd);
    op(1, BASES[1] + 32'h40, 1'b1, 1'b0, 32'h0, 4'h0, rd);
    chk("wr_rd_value", rd, 32'hA5A5_1234);

    // byte mask
    op(1, BASES[1] + 32'h8, 1'b0, 1'b1, 32'h1122_3344, 4'hF, rd);
    op(1, BASES[1] + 32'h8, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101, rd);
    op(1, BASES[1] + 32'h8, 1'b1, 1'b0, 32'h0, 4'h0, rd);
    chk("bytemask_value", rd, 32'h11BB_33DD);

    // error cases, zero-mask write, and the window edges
    for (int d = 0; d < 3; d++) begin
      op(d, BASES[d] + 32'h2, 1'b1, 1'b0, 32'h0, 4'h0, rd);
      op(d, BASES[d] + 32'(4 * DEPTH), 1'b1, 1'b0, 32'h0, 4'h0, rd);
      op(d, BASES[d] - 32'h4, 1'b1, 1'b0, 32'h0, 4'h0, rd);
      op(d, BASES[d], 1'b1, 1'b1, $urandom, 4'hF, rd);
      op(d, BASES[d] + 32'h4, 1'b0, 1'b1, $urandom, 4'h0, rd);
      op(d, BASES[d], 1'b1, 1'b0, 32'h0, 4'h0, rd);
      op(d, BASES[d] + 32'h4, 1'b1, 1'b0, 32'h0, 4'h0, rd);
      op(d, BASES[d] + 32'(4 * DEPTH - 4), 1'b1, 1'b0, 32'h0, 4'h0, rd);
    end

    // reset in the middle of a latency-3 write
    op(2, BASES[2] + 32'h10, 1'b0, 1'b1, 32'h0, 4'hF, rd);
    @(negedge clk);
    addr_a[2] = BASES[2] + 32'h10; we_a[2] = 1'b1; wdata_a[2] = 32'hDEAD_BEEF; wmask_a[2] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rstmid_ack", ack_a[2], 0);
      chk("rstmid_rdata", rdata_a[2], 0);
      @(posedge clk); #1;
    end
    we_a[2] = 1'b0;
    @(negedge clk); reset = 1'b0;
    op(2, BASES[2] + 32'h10, 1'b1, 1'b0, 32'h0, 4'h0, rd);
    chk("rstmid_keep", rd, 32'h0);

    // latency 0, back-to-back reads
    @(negedge clk);
    a = BASES[0] + 32'(4 * $urandom_range(0, DEPTH - 1));
    addr_a[0] = a; re_a[0] = 1'b1;
    exp_rd = mdl[0][word_idx(0, a)];
    for (int k = 0; k < 8; k++) begin
      wait_ack(0, cyc, ok);
      chk("b2b_data", rdata_a[0], exp_rd);
      chk("b2b_err", err_a[0], 0);
      chk("b2b_gap", cyc, (k == 0) ? 1 : 2);
      if (k < 7) begin
        a = BASES[0] + 32'(4 * $urandom_range(0, DEPTH - 1));
        addr_a[0] = a;
        exp_rd = mdl[0][word_idx(0, a)];
      end else begin
        re_a[0] = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("b2b_tail", ack_a[0], 0);

    // request held one cycle past ack
    @(negedge clk);
    addr_a[1] = BASES[1] + 32'h40; re_a[1] = 1'b1;
    wait_ack(1, cyc, ok);
    chk("held_first", rdata_a[1], mdl[1][16]);
    @(posedge clk); #1;
    chk("held_no_dup", ack_a[1], 0);
    @(posedge clk); #1;
    re_a[1] = 1'b0;
    nacks = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ack_a[1]) begin
        nacks++;
        chk("held_data", rdata_a[1], mdl[1][16]);
      end
    end
    chk("held_count", nacks, 1);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      int d = $urandom_range(0, 2);
      int kind = $urandom_range(0, 9);
      logic r = (kind == 0) || (kind >= 1 && kind <= 4);
      logic w = (kind == 0) || (kind >= 5);
      op(d, rand_addr(d), r, w, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
